fifo_read_checker: RTL

//  Synthesizable read-side consumer for the FIFO under test. Drains the FIFO in

---
 rtl/fifo_read_checker.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_read_checker.sv
// Read-side FIFO consumer: drains the FIFO in bursts, realigns data to the read
// latency and checks for a +1 incrementing stream, reporting errors and counts.
module fifo_read_checker #(
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1,
   parameter int BURST_LEN    = 4,
   parameter int GAP_LEN      = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  read_enable,
   output logic                  locked,
   output logic                  mismatch,
   output logic [DATA_WIDTH-1:0] expected,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic [CNT_WIDTH-1:0]  error_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BURST = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

   localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

   logic [1:0]              r_state;
   logic [BW-1:0]           r_burstCount;
   logic [GW-1:0]           r_gapCount;
   logic [READ_LATENCY-1:0] r_rdPipe;
   logic                    r_locked;
   logic                    r_mismatch;
   logic [DATA_WIDTH-1:0]   r_expected;
   logic [CNT_WIDTH-1:0]    r_wordCount;
   logic [CNT_WIDTH-1:0]    r_errorCount;

   logic                    w_readEnable;
   logic                    w_wordValid;
   logic                    w_dataMatch;
   logic [DATA_WIDTH-1:0]   w_nextExpected;

   assign w_readEnable   = (r_state == BURST) & enable & ~fifo_empty;
   assign w_wordValid    = r_rdPipe[READ_LATENCY-1];
   assign w_dataMatch    = (fifo_data == r_expected);
   assign w_nextExpected = fifo_data + 1'b1;

   // Burst/gap sequencing; dropping enable always parks the FSM with clean counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_burstCount <= '0;
         r_gapCount   <= '0;
      end else if (!enable) begin
         r_state      <= IDLE;
         r_burstCount <= '0;
         r_gapCount   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= BURST;
            end
            BURST: begin
               if (w_readEnable) begin
                  if (r_burstCount == BURST_LAST) begin
                     r_burstCount <= '0;
                     r_gapCount   <= '0;
                     r_state      <= (GAP_LEN == 0) ? BURST : GAP;
                  end else begin
                     r_burstCount <= r_burstCount + 1'b1;
                  end
               end
            end
            GAP: begin
               if (r_gapCount == GAP_LAST) begin
                  r_gapCount <= '0;
                  r_state    <= BURST;
               end else begin
                  r_gapCount <= r_gapCount + 1'b1;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_burstCount <= '0;
               r_gapCount   <= '0;
            end
         endcase
      end
   end

   // Read strobe delayed by the FIFO read latency; the last stage flags valid data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rdPipe <= '0;
      end else begin
         r_rdPipe[0] <= w_readEnable;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_rdPipe[i] <= r_rdPipe[i-1];
         end
      end
   end

   // The reference always resyncs to the observed word, so a single discontinuity
   // costs exactly one error.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_locked     <= 1'b0;
         r_mismatch   <= 1'b0;
         r_expected   <= '0;
         r_wordCount  <= '0;
         r_errorCount <= '0;
      end else begin
         r_mismatch <= 1'b0;
         if (w_wordValid) begin
            r_locked    <= 1'b1;
            r_expected  <= w_nextExpected;
            r_wordCount <= r_wordCount + 1'b1;
            if (r_locked && !w_dataMatch) begin
               r_mismatch <= 1'b1;
               if (r_errorCount != {CNT_WIDTH{1'b1}}) begin
                  r_errorCount <= r_errorCount + 1'b1;
               end
            end
         end
      end
   end

   assign read_enable = w_readEnable;
   assign locked      = r_locked;
   assign mismatch    = r_mismatch;
   assign expected    = r_expected;
   assign word_count  = r_wordCount;
   assign error_count = r_errorCount;

endmodule
